// File: rtl/rr_reg_arb_pkg.sv
// Shared types and helpers for the round-robin register arbiter.
// The pick and one-hot functions work on a fixed maximum width; callers cast the results down to their own size.
package rr_reg_arb_pkg;

  localparam int MAX_REQ    = 32;
  localparam int PICK_IDX_W = 5;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  typedef logic [PICK_IDX_W-1:0] req_idx_t;
  typedef logic [PICK_IDX_W:0]   cand_t;
  typedef logic [MAX_REQ-1:0]    req_vec_t;

  typedef struct packed {
    logic     found;
    req_idx_t idx;
  } pick_t;

  // Search last+1, last+2, ... and wrap modulo n. The search ends at last itself.
  function automatic pick_t rr_pick(input req_vec_t req, input int n, input req_idx_t last);
    pick_t p;
    cand_t cand;
    p = '0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      if (k <= n && !p.found) begin
        cand = cand_t'(last) + cand_t'(k);
        if (cand >= cand_t'(n)) cand = cand - cand_t'(n);
        if (req[cand[PICK_IDX_W-1:0]]) begin
          p.found = 1'b1;
          p.idx   = cand[PICK_IDX_W-1:0];
        end
      end
    end
    return p;
  endfunction

  function automatic req_vec_t onehot(input req_idx_t idx);
    req_vec_t v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_reg_arbiter_dff.sv
// WIDTH-bit storage register with a synchronous active-high reset and a load enable.
// Reset has priority, so a write that coincides with reset is lost.
module dff_sync_rs #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rs,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: flops are written with <= so every register samples pre-edge values; blocking here would race between processes.
  always_ff @(posedge clk) begin
    if (rs)      q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter that is the only writer of one shared WIDTH-bit register.
// A tenure ends when the owner drops its request or completes MAX_HOLD writes. Re-arbitration happens at that same edge.
module rr_reg_arbiter
  import rr_reg_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                     clk,
  input  logic                     rs,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   wdata,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     busy,
  output logic [WIDTH-1:0]         q,
  output logic                     valid
);

  localparam int OW = $clog2(N_REQ);
  localparam int HW = $clog2(MAX_HOLD + 1);

  state_t           state, state_nxt;
  logic [OW-1:0]    owner_r, owner_nxt, last_r, last_nxt;
  logic [HW-1:0]    hold_cnt, hold_nxt;
  logic [N_REQ-1:0] grant_r, grant_nxt;
  logic             valid_r;
  logic             wr_en, do_arb;
  req_vec_t         req_w;
  pick_t            pick;

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner_r;
    last_nxt  = last_r;
    hold_nxt  = hold_cnt;
    wr_en     = 1'b0;
    do_arb    = 1'b0;
    req_w     = '0;
    req_w[N_REQ-1:0] = req;
    pick      = rr_pick(req_w, N_REQ, req_idx_t'(last_r));

    case (state)
      ST_IDLE:  do_arb = |req;
      ST_GRANT: begin
        if (req[owner_r]) begin
          wr_en    = 1'b1;
          hold_nxt = hold_cnt + 1'b1;
          do_arb   = (hold_cnt == HW'(MAX_HOLD - 1));
        end else begin
          do_arb   = 1'b1;
        end
      end
      default:  state_nxt = ST_IDLE;
    endcase

    if (do_arb) begin
      hold_nxt = '0;
      if (pick.found) begin
        state_nxt = ST_GRANT;
        owner_nxt = OW'(pick.idx);
        last_nxt  = OW'(pick.idx);
      end else begin
        state_nxt = ST_IDLE;
        owner_nxt = '0;
      end
    end

    grant_nxt = (state_nxt == ST_GRANT) ? N_REQ'(onehot(req_idx_t'(owner_nxt))) : '0;
  end

  always_ff @(posedge clk) begin
    if (rs) begin
      state    <= ST_IDLE;
      owner_r  <= '0;
      last_r   <= OW'(N_REQ - 1);
      hold_cnt <= '0;
      grant_r  <= '0;
      valid_r  <= 1'b0;
    end else begin
      state    <= state_nxt;
      owner_r  <= owner_nxt;
      last_r   <= last_nxt;
      hold_cnt <= hold_nxt;
      grant_r  <= grant_nxt;
      valid_r  <= wr_en;
    end
  end

  dff_sync_rs #(.WIDTH(WIDTH)) u_store (
    .clk (clk),
    .rs  (rs),
    .en  (wr_en),
    .d   (wdata[owner_r*WIDTH +: WIDTH]),
    .q   (q)
  );

  assign grant = grant_r;
  assign owner = owner_r;
  assign busy  = (state == ST_GRANT);
  assign valid = valid_r;

endmodule
